// File: rtl/up3p_pkg.sv
// rtl/up3p_pkg.sv - opcode/state types and decode helpers shared by the up3p core
package up3p_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_LDI   = 4'h8,
    OP_JMP   = 4'h9,
    OP_JZ    = 4'hA,
    OP_JC    = 4'hB,
    OP_SHL   = 4'hC,
    OP_SHR   = 4'hD,
    OP_HALT  = 4'hE,
    OP_ILL   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH_U = 3'd0,
    S_LOAD_U  = 3'd1,
    S_FETCH_L = 3'd2,
    S_LOAD_L  = 3'd3,
    S_EXEC    = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // Ops whose operand is a memory address that must be read before retiring.
  function automatic logic is_mem_read(opcode_t op);
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // Ops executed entirely in S_EXEC that still update ac and flags.
  function automatic logic is_exec_ac_write(opcode_t op);
    case (op)
      OP_LDI, OP_SHL, OP_SHR: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/up3p_if.sv
// rtl/up3p_if.sv - single-port synchronous RAM bus between the up3p core and its memory
interface up3p_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/up3p_alu.sv
// rtl/up3p_alu.sv - combinational accumulator ALU: arithmetic, logic, shifts and carry/zero
module up3p_alu
  import up3p_pkg::*;
#(
  parameter int DW = 8
) (
  input  opcode_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic          c_out,
  output logic          z
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = a;
    c_out  = c_in;
    case (op)
      OP_LOAD, OP_LDI: result = b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c_out  = sum[DW];
      end
      // The extra top bit of a widened subtract is the borrow (b > a).
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0];
        c_out  = sum[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c_out  = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c_out  = a[0];
      end
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/up3p_core.sv
// rtl/up3p_core.sv - up3p accumulator CPU core with integrated fetch/decode/execute control
module up3p_core
  import up3p_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  up3p_if.master        mem,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ac,
  output logic [DW-1:0] opcode,
  output logic [DW-1:0] value,
  output logic          flag_z,
  output logic          flag_c,
  output logic          instr_done,
  output logic          halted,
  output logic          illegal
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ac_q, ac_d;
  logic [DW-1:0] ir_u_q, ir_u_d;
  logic [DW-1:0] ir_l_q, ir_l_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;

  logic [AW-1:0] addr_c;
  logic          we_c;
  logic          done_c;

  opcode_t       op;
  logic [AW-1:0] operand_addr;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          alu_c;
  logic          alu_z;

  assign op           = opcode_t'(ir_u_q[3:0]);
  assign operand_addr = ir_l_q[AW-1:0];
  // In S_WB the ALU consumes the memory operand; in S_EXEC it consumes the immediate.
  assign alu_b        = (state_q == S_WB) ? mem.mem_rdata : ir_l_q;

  up3p_alu #(
    .DW(DW)
  ) u_alu (
    .op    (op),
    .a     (ac_q),
    .b     (alu_b),
    .c_in  (c_q),
    .result(alu_result),
    .c_out (alu_c),
    .z     (alu_z)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    ir_u_d    = ir_u_q;
    ir_l_d    = ir_l_q;
    z_d       = z_q;
    c_d       = c_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    addr_c    = pc_q;
    we_c      = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      S_FETCH_U: begin
        if (run) begin
          pc_d    = pc_q + AW'(1);
          state_d = S_LOAD_U;
        end
      end
      S_LOAD_U: begin
        ir_u_d  = mem.mem_rdata;
        state_d = S_FETCH_L;
      end
      S_FETCH_L: begin
        pc_d    = pc_q + AW'(1);
        state_d = S_LOAD_L;
      end
      S_LOAD_L: begin
        ir_l_d  = mem.mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        addr_c  = operand_addr;
        state_d = S_FETCH_U;
        if (is_mem_read(op)) begin
          state_d = S_WB;
        end else begin
          done_c = 1'b1;
          if (is_exec_ac_write(op)) begin
            ac_d = alu_result;
            z_d  = alu_z;
            c_d  = alu_c;
          end
          case (op)
            OP_STORE: we_c = 1'b1;
            OP_JMP:   pc_d = operand_addr;
            OP_JZ:    if (z_q) pc_d = operand_addr;
            OP_JC:    if (c_q) pc_d = operand_addr;
            OP_HALT: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            OP_ILL: begin
              halted_d  = 1'b1;
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_WB: begin
        addr_c  = operand_addr;
        ac_d    = alu_result;
        z_d     = alu_z;
        c_d     = alu_c;
        done_c  = 1'b1;
        state_d = S_FETCH_U;
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH_U;
      pc_q      <= RESET_PC;
      ac_q      <= '0;
      ir_u_q    <= '0;
      ir_l_q    <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ac_q      <= ac_d;
      ir_u_q    <= ir_u_d;
      ir_l_q    <= ir_l_d;
      z_q       <= z_d;
      c_q       <= c_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = ac_q;
  assign mem.mem_we    = we_c;

  assign pc         = pc_q;
  assign ac         = ac_q;
  assign opcode     = ir_u_q;
  assign value      = ir_l_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign instr_done = done_c;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_up3p_core.sv
// tb/tb_up3p_core.sv - scoreboard bench for up3p_core against an instruction-level model
module tb_up3p_core;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b1;
  logic [AW-1:0] pc;
  logic [DW-1:0] ac, opcode, value;
  logic          flag_z, flag_c, instr_done, halted, illegal;

  always #5 clk = ~clk;

  up3p_if #(.DW(DW), .AW(AW)) bus ();

  up3p_core #(
    .DW(DW),
    .AW(AW),
    .RESET_PC(8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem       (bus),
    .pc        (pc),
    .ac        (ac),
    .opcode    (opcode),
    .value     (value),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .instr_done(instr_done),
    .halted    (halted),
    .illegal   (illegal)
  );

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] rm  [256];
  logic       ld_req = 1'b0;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ac;
    logic       z;
    logic       c;
    logic       h;
    logic       il;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   sb_en = 1'b0;
  bit   lat_chk = 1'b0;
  bit   pend = 1'b0;
  int   last_ret = -1;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp_v);
    end
  endtask

  // Instruction-set-level reference: interprets the image and records the
  // architectural state expected after each retired instruction.
  task automatic model_run(input int n_max);
    logic [7:0] p, a, opd, m, q;
    logic       z, c, h, il;
    logic [8:0] w;
    int         op;
    exp_t       e;
    p = 8'h00; a = 8'h00; z = 1'b0; c = 1'b0; h = 1'b0; il = 1'b0;
    for (int i = 0; i < 256; i++) rm[i] = img[i];
    for (int k = 0; k < n_max && !h; k++) begin
      op  = int'(rm[p] & 8'h0F);
      q   = p + 8'd1;
      opd = rm[q];
      p   = p + 8'd2;
      m   = rm[opd];
      e.lat = 5;
      case (op)
        1:  begin a = m; e.lat = 6; end
        2:  rm[opd] = a;
        3:  begin w = {1'b0, a} + {1'b0, m}; a = w[7:0]; c = w[8]; e.lat = 6; end
        4:  begin c = (m > a); a = a - m; e.lat = 6; end
        5:  begin a = a & m; e.lat = 6; end
        6:  begin a = a | m; e.lat = 6; end
        7:  begin a = a ^ m; e.lat = 6; end
        8:  a = opd;
        9:  p = opd;
        10: if (z) p = opd;
        11: if (c) p = opd;
        12: begin c = a[7]; a = a << 1; end
        13: begin c = a[0]; a = a >> 1; end
        14: h = 1'b1;
        15: begin h = 1'b1; il = 1'b1; end
        default: ;
      endcase
      if (op == 1 || (op >= 3 && op <= 8) || op == 12 || op == 13) z = (a == 8'h00);
      e.pc = p; e.ac = a; e.z = z; e.c = c; e.h = h; e.il = il;
      sbq.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per retirement, compares the state visible the cycle after.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        pend     = 1'b0;
        last_ret = -1;
      end else begin
        if (pend) begin
          chk("retire_pc", pc, cur.pc);
          chk("retire_ac", ac, cur.ac);
          chk("retire_z", flag_z, cur.z);
          chk("retire_c", flag_c, cur.c);
          chk("retire_halted", halted, cur.h);
          chk("retire_illegal", illegal, cur.il);
          pend = 1'b0;
        end
        if (instr_done && sb_en) begin
          if (sbq.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            cur  = sbq.pop_front();
            pend = 1'b1;
            if (lat_chk) chk("latency", cyc - last_ret, cur.lat);
          end
          last_ret = cyc;
        end
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic start_prog(input int n_max, input bit en);
    sbq.delete();
    if (en) model_run(n_max);
    sb_en = en;
    reset = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_retires(input int n, input int bound, output int at_cyc);
    int cnt;
    cnt = 0;
    at_cyc = -1;
    for (int t = 0; t < bound && cnt < n; t++) begin
      @(negedge clk);
      if (instr_done) begin
        cnt++;
        at_cyc = cyc;
      end
    end
    chk("retire_count", cnt, n);
  endtask

  task automatic finish_prog();
    int errs;
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== rm[i]) errs++;
    chk("mem_image", errs, 0);
  endtask

  initial begin : stim
    int at, n, cnt, found;
    logic [3:0] opn;

    // Asynchronous reset with no clock edge yet
    #2 reset = 1'b1;
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ac", ac, 8'h00);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_done", instr_done, 1'b0);

    // LDI 05; ADD [20]; STORE [21]; HALT
    clear_img();
    img[0] = 8'h08; img[1] = 8'h05; img[2] = 8'h03; img[3] = 8'h20;
    img[4] = 8'h02; img[5] = 8'h21; img[6] = 8'h0E; img[7] = 8'h00;
    img[8'h20] = 8'hFC;
    lat_chk = 1'b1;
    start_prog(10, 1'b1);
    @(posedge clk);
    #1 chk("first_edge_pc", pc, 8'h01);
    wait_retires(4, 60, at);
    chk("fetch_to_halt_cycles", at + 1, 21);
    finish_prog();
    chk("p1_m21", mem[8'h21], 8'h01);
    chk("p1_c", flag_c, 1'b1);
    chk("p1_z", flag_z, 1'b0);
    chk("p1_halted", halted, 1'b1);
    chk("p1_pc", pc, 8'h08);
    chk("p1_opcode", opcode, 8'h0E);

    // LDI 33; SUB [30]; JZ 40; JC 00 (not taken); HALT
    clear_img();
    img[0] = 8'h08; img[1] = 8'h33; img[2] = 8'h04; img[3] = 8'h30;
    img[4] = 8'h0A; img[5] = 8'h40; img[8'h40] = 8'h0B; img[8'h41] = 8'h00;
    img[8'h42] = 8'h0E; img[8'h30] = 8'h33;
    start_prog(10, 1'b1);
    wait_retires(sbq.size(), 80, at);
    finish_prog();
    chk("p2_z", flag_z, 1'b1);
    chk("p2_c", flag_c, 1'b0);
    chk("p2_pc", pc, 8'h44);

    // JMP FE, NOP at FE/FF, wrap to LDI 07 at 00
    clear_img();
    img[0] = 8'h08; img[1] = 8'h07; img[2] = 8'h09; img[3] = 8'hFE;
    start_prog(5, 1'b1);
    wait_retires(5, 60, at);
    finish_prog();
    chk("p3_ac", ac, 8'h07);

    // run dropped during S_LOAD_L of LDI 9
    clear_img();
    img[0] = 8'h08; img[1] = 8'h09; img[2] = 8'h08; img[3] = 8'h03;
    img[4] = 8'h0E;
    lat_chk = 1'b0;
    start_prog(3, 1'b1);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    wait_retires(1, 20, at);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (instr_done) cnt++;
    end
    chk("pause_no_done", cnt, 0);
    chk("pause_ac", ac, 8'h09);
    chk("pause_pc", pc, 8'h02);
    chk("pause_addr", bus.mem_addr, 8'h02);
    run = 1'b1;
    @(posedge clk);
    #1 chk("resume_pc", pc, 8'h03);
    wait_retires(2, 30, at);
    finish_prog();

    // async reset while STORE drives mem_we
    clear_img();
    img[0] = 8'h08; img[1] = 8'h55; img[2] = 8'h02; img[3] = 8'h80;
    img[4] = 8'h0E;
    start_prog(0, 1'b0);
    found = 0;
    for (int t = 0; t < 30 && found == 0; t++) begin
      @(negedge clk);
      if (bus.mem_we) found = 1;
    end
    chk("store_we_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_we_low", bus.mem_we, 1'b0);
    chk("async_pc", pc, 8'h00);
    @(posedge clk);
    #1 chk("store_blocked", mem[8'h80], 8'h00);

    // illegal opcode freezes the core
    clear_img();
    img[0] = 8'h0F; img[1] = 8'h00; img[2] = 8'h02; img[3] = 8'h10;
    lat_chk = 1'b1;
    start_prog(8, 1'b1);
    wait_retires(1, 20, at);
    cnt = 0;
    found = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_we) cnt++;
      if (instr_done) found++;
    end
    chk("ill_no_writes", cnt, 0);
    chk("ill_no_done", found, 0);
    chk("ill_pc_frozen", pc, 8'h02);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_halted", halted, 1'b1);
    finish_prog();

    // randomized programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 256; i += 2) begin
        opn = ($urandom_range(0, 63) == 0) ? 4'hE : 4'($urandom_range(0, 13));
        img[i] = {4'($urandom), opn};
      end
      start_prog(60, 1'b1);
      n = sbq.size();
      wait_retires(n, 60 * 7 + 10, at);
      finish_prog();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
